// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder-buffer allocate/commit controller.
// Contents: default ROB depth, the tag type at the default depth, and the FSM state type.
package rob_pkg;

    localparam int unsigned ROB_SIZE_DEF = 32;
    localparam int unsigned ADDR_W_DEF   = $clog2(ROB_SIZE_DEF);

    typedef logic [ADDR_W_DEF-1:0] rob_tag_t;

    typedef enum logic {
        RUN,
        FLUSH
    } rob_state_e;

endpackage

// File: rtl/rob_alloc_commit_ctrl_if.sv
// Groups the dispatch handshake, the writeback completion bus, the commit handshake and the
// ROB storage pointers/status into one bundle.
//   slave  : the controller (drives alloc_ready/tag, commit_*, flush, head/tail/count/status)
//   master : the surrounding pipeline (drives alloc_valid, cmpl_*, commit_ready)
interface rob_alloc_commit_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              alloc_valid_i;
    logic              alloc_ready_o;
    logic [ADDR_W-1:0] alloc_tag_o;

    logic              cmpl_valid_i;
    logic [ADDR_W-1:0] cmpl_tag_i;
    logic              cmpl_exc_i;

    logic              commit_valid_o;
    logic              commit_ready_i;
    logic [ADDR_W-1:0] commit_tag_o;
    logic              commit_exc_o;

    logic              flush_o;
    logic [ADDR_W-1:0] head_o;
    logic [ADDR_W-1:0] tail_o;
    logic [ADDR_W:0]   count_o;
    logic              empty_o;
    logic              full_o;

    modport slave (
        input  alloc_valid_i, cmpl_valid_i, cmpl_tag_i, cmpl_exc_i, commit_ready_i,
        output alloc_ready_o, alloc_tag_o, commit_valid_o, commit_tag_o, commit_exc_o,
        output flush_o, head_o, tail_o, count_o, empty_o, full_o
    );

    modport master (
        output alloc_valid_i, cmpl_valid_i, cmpl_tag_i, cmpl_exc_i, commit_ready_i,
        input  alloc_ready_o, alloc_tag_o, commit_valid_o, commit_tag_o, commit_exc_o,
        input  flush_o, head_o, tail_o, count_o, empty_o, full_o
    );

endinterface

// File: rtl/rob_ptr_ctr.sv
// Wrapping ROB pointer. Increments modulo 2**WIDTH; clr_i has priority and returns it to 0.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   inc_i            : advance pointer by one
//   clr_i            : synchronous clear to 0
//   ptr_o            : current pointer
module rob_ptr_ctr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            // Power-of-two depth: natural overflow is the modulo wrap.
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_alloc_commit_ctrl.sv
// Reorder-buffer sequencing controller: hands out tags to dispatch, records writeback
// completions, retires in order, and flushes the whole ROB after an excepting entry retires.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   bus (slave)      : alloc handshake, completion bus, commit handshake, flush pulse,
//                      head/tail pointers and count/empty/full status
module rob_alloc_commit_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned ROB_SIZE = ROB_SIZE_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    rob_alloc_commit_ctrl_if.slave  bus
);

    localparam int unsigned     ADDR_W   = $clog2(ROB_SIZE);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(ROB_SIZE);

    rob_state_e          state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ROB_SIZE-1:0] done_q, done_d;
    logic [ROB_SIZE-1:0] exc_q, exc_d;
    logic [ADDR_W-1:0]   head, tail;
    logic [ADDR_W-1:0]   cmpl_off;
    logic                run, empty, full;
    logic                alloc_ready, alloc_hs;
    logic                commit_valid, commit_exc, commit_hs;
    logic                cmpl_hit, ptr_clr;

    assign run   = (state_q == RUN);
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Ready depends on registered count only; a same-cycle commit does not free a slot.
    assign alloc_ready  = run & ~full;
    assign alloc_hs     = bus.alloc_valid_i & alloc_ready;
    assign commit_valid = run & ~empty & done_q[head];
    assign commit_exc   = exc_q[head];
    assign commit_hs    = commit_valid & bus.commit_ready_i;

    // Tag is live iff its distance from head is below the occupancy.
    assign cmpl_off = bus.cmpl_tag_i - head;
    assign cmpl_hit = run & bus.cmpl_valid_i & ({1'b0, cmpl_off} < count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        exc_d   = exc_q;
        ptr_clr = 1'b0;
        case (state_q)
            RUN: begin
                if (alloc_hs) begin
                    done_d[tail] = 1'b0;
                    exc_d[tail]  = 1'b0;
                end
                // cmpl_hit never targets tail: tail is outside the live window unless full,
                // and a full ROB cannot allocate.
                if (cmpl_hit) begin
                    done_d[bus.cmpl_tag_i] = 1'b1;
                    if (bus.cmpl_exc_i) begin
                        exc_d[bus.cmpl_tag_i] = 1'b1;
                    end
                end
                count_d = count_q + (ADDR_W + 1)'(alloc_hs) - (ADDR_W + 1)'(commit_hs);
                if (commit_hs && commit_exc) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = RUN;
                count_d = '0;
                done_d  = '0;
                exc_d   = '0;
                ptr_clr = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
            count_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    rob_ptr_ctr #(
        .WIDTH (ADDR_W)
    ) u_head (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (commit_hs),
        .clr_i     (ptr_clr),
        .ptr_o     (head)
    );

    rob_ptr_ctr #(
        .WIDTH (ADDR_W)
    ) u_tail (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (alloc_hs),
        .clr_i     (ptr_clr),
        .ptr_o     (tail)
    );

    assign bus.alloc_ready_o  = alloc_ready;
    assign bus.alloc_tag_o    = tail;
    assign bus.commit_valid_o = commit_valid;
    assign bus.commit_tag_o   = head;
    assign bus.commit_exc_o   = commit_exc;
    assign bus.flush_o        = (state_q == FLUSH);
    assign bus.head_o         = head;
    assign bus.tail_o         = tail;
    assign bus.count_o        = count_q;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;

endmodule

// File: tb/tb_rob_alloc_commit_ctrl.sv
// Directed bench for rob_alloc_commit_ctrl at ROB_SIZE=8: allocation to full, in-order
// commit, commit back-pressure, concurrent alloc/commit, stale completions, async reset,
// and exception-triggered flush.
module tb_rob_alloc_commit_ctrl;

    localparam int unsigned ROB_SIZE = 8;
    localparam int unsigned ADDR_W   = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    rob_alloc_commit_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    rob_alloc_commit_ctrl #(
        .ROB_SIZE (ROB_SIZE)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic complete(input logic [ADDR_W-1:0] tag, input logic exc);
        bus.cmpl_valid_i = 1'b1;
        bus.cmpl_tag_i   = tag;
        bus.cmpl_exc_i   = exc;
        step();
        bus.cmpl_valid_i = 1'b0;
        bus.cmpl_exc_i   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n              = 1'b0;
        bus.alloc_valid_i  = 1'b0;
        bus.cmpl_valid_i   = 1'b0;
        bus.cmpl_tag_i     = '0;
        bus.cmpl_exc_i     = 1'b0;
        bus.commit_ready_i = 1'b0;
        #12 rst_n = 1'b1;
        step();

        // 1. reset state
        chk("rst_head", 32'(bus.head_o), 0);
        chk("rst_tail", 32'(bus.tail_o), 0);
        chk("rst_count", 32'(bus.count_o), 0);
        chk("rst_empty", 32'(bus.empty_o), 1);
        chk("rst_full", 32'(bus.full_o), 0);
        chk("rst_alloc_ready", 32'(bus.alloc_ready_o), 1);
        chk("rst_commit_valid", 32'(bus.commit_valid_o), 0);
        chk("rst_flush", 32'(bus.flush_o), 0);

        // 2. fill all 8 entries back to back
        bus.alloc_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", 32'(bus.alloc_ready_o), 1);
            chk("fill_tag", 32'(bus.alloc_tag_o), 32'(i));
            step();
        end
        chk("full_flag", 32'(bus.full_o), 1);
        chk("full_count", 32'(bus.count_o), 8);
        chk("full_ready", 32'(bus.alloc_ready_o), 0);
        chk("full_tail_wrap", 32'(bus.tail_o), 0);
        step();  // 9th request must not be granted
        chk("ninth_count", 32'(bus.count_o), 8);
        chk("ninth_tail", 32'(bus.tail_o), 0);
        bus.alloc_valid_i = 1'b0;

        // 3. out-of-order completion, in-order commit
        complete(3'd2, 1'b0);
        chk("c2_no_commit", 32'(bus.commit_valid_o), 0);
        complete(3'd1, 1'b0);
        chk("c1_no_commit", 32'(bus.commit_valid_o), 0);
        complete(3'd0, 1'b0);
        chk("c0_commit_valid", 32'(bus.commit_valid_o), 1);
        bus.commit_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ord_valid", 32'(bus.commit_valid_o), 1);
            chk("ord_tag", 32'(bus.commit_tag_o), 32'(i));
            step();
        end
        chk("ord_count", 32'(bus.count_o), 5);
        chk("ord_head", 32'(bus.head_o), 3);
        chk("ord_valid_low", 32'(bus.commit_valid_o), 0);
        bus.commit_ready_i = 1'b0;

        // 4. back-pressure holds commit; then concurrent alloc + commit
        complete(3'd3, 1'b0);
        chk("bp_valid0", 32'(bus.commit_valid_o), 1);
        chk("bp_tag0", 32'(bus.commit_tag_o), 3);
        step();
        chk("bp_valid1", 32'(bus.commit_valid_o), 1);
        chk("bp_tag1", 32'(bus.commit_tag_o), 3);
        chk("bp_head", 32'(bus.head_o), 3);
        bus.alloc_valid_i  = 1'b1;
        bus.commit_ready_i = 1'b1;
        chk("both_alloc_tag", 32'(bus.alloc_tag_o), 0);
        step();
        bus.alloc_valid_i  = 1'b0;
        bus.commit_ready_i = 1'b0;
        chk("both_count", 32'(bus.count_o), 5);
        chk("both_head", 32'(bus.head_o), 4);
        chk("both_tail", 32'(bus.tail_o), 1);

        // 5. live entries are 4,5,6,7,0; tag 2 is stale
        complete(3'd2, 1'b0);
        chk("stale_no_commit", 32'(bus.commit_valid_o), 0);
        complete(3'd4, 1'b0);
        chk("live_valid", 32'(bus.commit_valid_o), 1);
        chk("live_tag", 32'(bus.commit_tag_o), 4);
        bus.commit_ready_i = 1'b1;
        step();
        bus.commit_ready_i = 1'b0;
        chk("live_head", 32'(bus.head_o), 5);
        chk("live_count", 32'(bus.count_o), 4);
        chk("live_next_low", 32'(bus.commit_valid_o), 0);

        // async reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("arst_tail", 32'(bus.tail_o), 0);
        chk("arst_head", 32'(bus.head_o), 0);
        chk("arst_count", 32'(bus.count_o), 0);
        #3 rst_n = 1'b1;
        step();

        // 6. tag 3 excepts; commit 0..3 then flush
        bus.alloc_valid_i = 1'b1;
        repeat (4) step();
        bus.alloc_valid_i = 1'b0;
        chk("ex_count", 32'(bus.count_o), 4);
        complete(3'd3, 1'b1);
        complete(3'd0, 1'b0);
        complete(3'd1, 1'b0);
        complete(3'd2, 1'b0);
        bus.commit_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ex_ord_tag", 32'(bus.commit_tag_o), 32'(i));
            chk("ex_ord_exc", 32'(bus.commit_exc_o), 0);
            step();
        end
        chk("ex_valid", 32'(bus.commit_valid_o), 1);
        chk("ex_tag", 32'(bus.commit_tag_o), 3);
        chk("ex_exc", 32'(bus.commit_exc_o), 1);
        bus.alloc_valid_i = 1'b1;  // accepted, then discarded by the flush
        step();
        bus.commit_ready_i = 1'b0;
        chk("fl_flush", 32'(bus.flush_o), 1);
        chk("fl_alloc_ready", 32'(bus.alloc_ready_o), 0);
        chk("fl_commit_valid", 32'(bus.commit_valid_o), 0);
        chk("fl_tail", 32'(bus.tail_o), 5);
        chk("fl_count", 32'(bus.count_o), 1);
        bus.cmpl_valid_i = 1'b1;
        bus.cmpl_tag_i   = 3'd4;
        step();
        bus.cmpl_valid_i  = 1'b0;
        bus.alloc_valid_i = 1'b0;
        chk("post_flush", 32'(bus.flush_o), 0);
        chk("post_head", 32'(bus.head_o), 0);
        chk("post_tail", 32'(bus.tail_o), 0);
        chk("post_count", 32'(bus.count_o), 0);
        chk("post_empty", 32'(bus.empty_o), 1);
        chk("post_alloc_ready", 32'(bus.alloc_ready_o), 1);
        chk("post_commit_valid", 32'(bus.commit_valid_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
